// File: rtl/matrix_line_fifo_if.sv
// Write/read handshake bundle for matrix_line_fifo.
// The master side produces pixels into the FIFO and pops from its head.
interface matrix_line_fifo_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_vld;
  logic                  rd_en;
  logic                  rd_vld;
  logic [DATA_WIDTH-1:0] rd_data;

  modport master (
    output wr_en, wr_data, rd_en,
    input  wr_vld, rd_vld, rd_data
  );

  modport slave (
    input  wr_en, wr_data, rd_en,
    output wr_vld, rd_vld, rd_data
  );
endinterface

// File: rtl/matrix_line_fifo.sv
// First-word-fall-through line FIFO: block RAM with registered read feeding a
// one-word head register, fill count/flags, sticky errors and line priming.
module matrix_line_fifo #(
  parameter int DATA_WIDTH  = 8,
  parameter int DEPTH_WIDTH = 12,
  parameter int AF_LEVEL    = 2**DEPTH_WIDTH - 4,
  parameter int AE_LEVEL    = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   prime_en,
  input  logic [DEPTH_WIDTH:0]   line_len,
  matrix_line_fifo_if.slave      fifo,
  output logic [DEPTH_WIDTH:0]   count,
  output logic                   almost_full,
  output logic                   almost_empty,
  output logic                   overflow,
  output logic                   underflow
);

  localparam int DEPTH = 2**DEPTH_WIDTH;
  localparam logic [DEPTH_WIDTH:0] CAPACITY  = (DEPTH_WIDTH+1)'(DEPTH);
  localparam logic [DEPTH_WIDTH:0] AF_THRESH = (DEPTH_WIDTH+1)'(AF_LEVEL);
  localparam logic [DEPTH_WIDTH:0] AE_THRESH = (DEPTH_WIDTH+1)'(AE_LEVEL);

  typedef enum logic {IDLE, PRIMED} prime_state_t;

  prime_state_t          state;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DEPTH_WIDTH:0]  wr_ptr;
  logic [DEPTH_WIDTH:0]  rd_ptr;
  logic [DEPTH_WIDTH:0]  mem_cnt;
  logic [DEPTH_WIDTH:0]  count_next;
  logic [DATA_WIDTH-1:0] ram_q;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  ram_vld;
  logic                  out_vld;
  logic                  wr_vld_q;
  logic                  head_vld;
  logic                  push;
  logic                  pop;
  logic                  out_take;
  logic                  issue;

  assign head_vld     = out_vld && (state == PRIMED);
  assign fifo.wr_vld  = wr_vld_q;
  assign fifo.rd_vld  = head_vld;
  assign fifo.rd_data = out_data;

  assign push     = fifo.wr_en && wr_vld_q;
  assign pop      = fifo.rd_en && head_vld;
  assign mem_cnt  = wr_ptr - rd_ptr;
  assign out_take = !out_vld || pop;
  // A RAM read is issued only when the read register is free or drains this cycle.
  assign issue    = (mem_cnt != '0) && (!ram_vld || out_take);

  always_comb begin
    count_next = count;
    if (push && !pop) begin
      count_next = count + 1'b1;
    end else if (!push && pop) begin
      count_next = count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[DEPTH_WIDTH-1:0]] <= fifo.wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (issue) begin
      ram_q <= mem[rd_ptr[DEPTH_WIDTH-1:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state        <= IDLE;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      ram_vld      <= 1'b0;
      out_vld      <= 1'b0;
      out_data     <= '0;
      count        <= '0;
      wr_vld_q     <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (issue) begin
        rd_ptr  <= rd_ptr + 1'b1;
        ram_vld <= 1'b1;
      end else if (ram_vld && out_take) begin
        ram_vld <= 1'b0;
      end
      if (out_take) begin
        out_vld <= ram_vld;
        if (ram_vld) begin
          out_data <= ram_q;
        end
      end

      count        <= count_next;
      wr_vld_q     <= count_next < CAPACITY;
      almost_full  <= count_next >= AF_THRESH;
      almost_empty <= count_next <= AE_THRESH;

      if (fifo.wr_en && !wr_vld_q) begin
        overflow <= 1'b1;
      end
      if (fifo.rd_en && !head_vld) begin
        underflow <= 1'b1;
      end

      // Priming holds the head back until a whole line is buffered.
      case (state)
        IDLE: begin
          if (!prime_en || (count >= line_len)) begin
            state <= PRIMED;
          end
        end
        PRIMED: begin
          if ((count == 1) && pop && !push) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_line_fifo.sv
// Scoreboard bench for matrix_line_fifo (8-bit data, 16-word capacity).
module tb_matrix_line_fifo;

  localparam int DW  = 8;
  localparam int DPW = 4;
  localparam int CAP = 16;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           flush = 1'b0;
  logic           prime_en = 1'b0;
  logic [DPW:0]   line_len = '0;
  logic [DPW:0]   count;
  logic           almost_full;
  logic           almost_empty;
  logic           overflow;
  logic           underflow;

  matrix_line_fifo_if #(.DATA_WIDTH(DW)) fifo_if ();

  matrix_line_fifo #(
    .DATA_WIDTH (DW),
    .DEPTH_WIDTH(DPW),
    .AF_LEVEL   (CAP - 4),
    .AE_LEVEL   (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .prime_en    (prime_en),
    .line_len    (line_len),
    .fifo        (fifo_if),
    .count       (count),
    .almost_full (almost_full),
    .almost_empty(almost_empty),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  always #5 clk = ~clk;

  int            compared = 0;
  int            mismatched = 0;
  logic [DW-1:0] exp_q[$];
  int            model_count = 0;
  bit            model_ovf = 0;
  bit            model_unf = 0;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic clearModel();
    exp_q.delete();
    model_count = 0;
    model_ovf   = 0;
    model_unf   = 0;
  endtask

  // One clock of stimulus: decide acceptance from the model, score pops, then check state after the edge.
  task automatic applyStimulus(input bit we, input logic [DW-1:0] wd, input bit re);
    bit w_acc;
    bit r_acc;
    @(negedge clk);
    fifo_if.wr_en   = we;
    fifo_if.wr_data = wd;
    fifo_if.rd_en   = re;
    checkOutput("wr_vld", fifo_if.wr_vld, model_count < CAP);
    w_acc = we && (model_count < CAP);
    r_acc = re && fifo_if.rd_vld;
    if (we && !w_acc) model_ovf = 1;
    if (re && !fifo_if.rd_vld) model_unf = 1;
    if (r_acc) begin
      if (exp_q.size() == 0) checkOutput("pop_unexpected", 1, 0);
      else checkOutput("rd_data", fifo_if.rd_data, exp_q.pop_front());
    end
    if (w_acc) exp_q.push_back(wd);
    model_count = model_count + int'(w_acc) - int'(r_acc);
    @(posedge clk);
    #1;
    fifo_if.wr_en = 1'b0;
    fifo_if.rd_en = 1'b0;
    checkOutput("count", count, model_count);
    checkOutput("almost_full", almost_full, model_count >= CAP - 4);
    checkOutput("almost_empty", almost_empty, model_count <= 4);
    checkOutput("overflow", overflow, model_ovf);
    checkOutput("underflow", underflow, model_unf);
  endtask

  task automatic doReset(input bit prime, input bit use_flush);
    @(negedge clk);
    fifo_if.wr_en = 1'b0;
    fifo_if.rd_en = 1'b0;
    prime_en = prime;
    if (use_flush) flush = 1'b1;
    else rst = 1'b1;
    @(posedge clk);
    #1;
    rst   = 1'b0;
    flush = 1'b0;
    clearModel();
    checkOutput("clr_count", count, 0);
    checkOutput("clr_wr_vld", fifo_if.wr_vld, 1);
    checkOutput("clr_rd_vld", fifo_if.rd_vld, 0);
    checkOutput("clr_rd_data", fifo_if.rd_data, 0);
    checkOutput("clr_almost_full", almost_full, 0);
    checkOutput("clr_almost_empty", almost_empty, 1);
    checkOutput("clr_overflow", overflow, 0);
    checkOutput("clr_underflow", underflow, 0);
  endtask

  task automatic drain(input int max_cycles);
    int n = 0;
    while (exp_q.size() > 0 && n < max_cycles) begin
      applyStimulus(1'b0, '0, 1'b1);
      n++;
    end
    if (exp_q.size() > 0) checkOutput("drain_timeout", exp_q.size(), 0);
  endtask

  initial begin
    fifo_if.wr_en   = 1'b0;
    fifo_if.wr_data = '0;
    fifo_if.rd_en   = 1'b0;

    // Fill to capacity, then stream out with rd_en held high.
    doReset(1'b0, 1'b0);
    for (int i = 1; i <= 16; i++) applyStimulus(1'b1, DW'(i), 1'b0);
    checkOutput("full_wr_vld", fifo_if.wr_vld, 0);
    checkOutput("full_count", count, 16);
    for (int i = 0; i < 16; i++) begin
      checkOutput("no_gap_rd_vld", fifo_if.rd_vld, 1);
      applyStimulus(1'b0, '0, 1'b1);
    end
    checkOutput("drained_rd_vld", fifo_if.rd_vld, 0);
    checkOutput("drained_count", count, 0);

    // Two-edge write-to-read latency on an empty FIFO.
    applyStimulus(1'b0, '0, 1'b0);
    applyStimulus(1'b1, 8'hA5, 1'b0);
    checkOutput("lat_n_rd_vld", fifo_if.rd_vld, 0);
    applyStimulus(1'b0, '0, 1'b0);
    checkOutput("lat_n1_rd_vld", fifo_if.rd_vld, 0);
    applyStimulus(1'b0, '0, 1'b0);
    checkOutput("lat_n2_rd_vld", fifo_if.rd_vld, 1);
    checkOutput("lat_n2_rd_data", fifo_if.rd_data, 8'hA5);
    applyStimulus(1'b0, '0, 1'b1);

    // Write+pop while full: write rejected, pop proceeds.
    doReset(1'b0, 1'b0);
    for (int i = 1; i <= 16; i++) applyStimulus(1'b1, DW'(i), 1'b0);
    applyStimulus(1'b1, 8'h77, 1'b1);
    checkOutput("ovf_count", count, 15);
    checkOutput("ovf_flag", overflow, 1);
    checkOutput("ovf_wr_vld_back", fifo_if.wr_vld, 1);
    applyStimulus(1'b1, 8'h78, 1'b0);
    drain(40);

    // Line priming with line_len=5.
    line_len = 5;
    doReset(1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, DW'(8'h10 + i), 1'b0);
      checkOutput("prime_hold_rd_vld", fifo_if.rd_vld, 0);
    end
    applyStimulus(1'b0, '0, 1'b0);
    checkOutput("primed_rd_vld", fifo_if.rd_vld, 1);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, '0, 1'b1);
    applyStimulus(1'b1, 8'h99, 1'b0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, '0, 1'b0);
      checkOutput("reprime_rd_vld", fifo_if.rd_vld, 0);
    end
    line_len = 0;

    // Random streaming with the handshake respected; exercises pointer wrap.
    doReset(1'b0, 1'b0);
    begin
      int sent = 0;
      int cycles = 0;
      while ((sent < 100 || exp_q.size() > 0) && cycles < 3000) begin
        bit we;
        bit re;
        we = ($urandom_range(0, 1) == 1) && (sent < 100) && fifo_if.wr_vld;
        re = ($urandom_range(0, 1) == 1) && fifo_if.rd_vld;
        if (we) sent++;
        applyStimulus(we, DW'($urandom), re);
        cycles++;
      end
      if (cycles >= 3000) checkOutput("stream_timeout", exp_q.size(), 0);
    end
    checkOutput("stream_no_ovf", overflow, 0);
    checkOutput("stream_no_unf", underflow, 0);

    // Flush mid-operation, then reset mid-operation.
    for (int pass = 0; pass < 2; pass++) begin
      doReset(1'b0, 1'b0);
      applyStimulus(1'b0, '0, 1'b1);
      for (int i = 0; i < 9; i++) applyStimulus(1'b1, DW'(8'h40 + i), 1'b0);
      checkOutput("pre_clear_count", count, 9);
      doReset(1'b0, pass == 0);
      applyStimulus(1'b1, 8'h3C, 1'b0);
      applyStimulus(1'b0, '0, 1'b0);
      applyStimulus(1'b0, '0, 1'b0);
      checkOutput("post_clear_head", fifo_if.rd_data, 8'h3C);
      drain(10);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/matrix_line_fifo.md
Name: matrix_line_fifo

Overview:
- Single-clock, parametrised prefetch (first-word-fall-through) FIFO for the filter line-buffer path; successor to the fixed 8-bit/4096-deep prefetch buffer.
- Adds configurable width/depth, fill count, almost-full/almost-empty flags, and a line-priming mode: read side stays invalid until a programmable number of words (one image line) is stored.
- Adds flush, and sticky overflow/underflow flags.
- Sits between the pixel stream and the 3x3 matrix generator; one instance per line delay.

Parameters:
- DATA_WIDTH, 8, width of wr_data/rd_data (1..64).
- DEPTH_WIDTH, 12, total capacity = 2**DEPTH_WIDTH words, including the prefetch output stage (4..16).
- AF_LEVEL, 2**DEPTH_WIDTH-4, almost_full asserted when count >= AF_LEVEL.
- AE_LEVEL, 4, almost_empty asserted when count <= AE_LEVEL.

Ports:
- clk  in  1  single clock for all logic.
- rst  in  1  synchronous reset, active-high.
- flush  in  1  synchronous clear of contents and sticky flags; one-cycle pulse sufficient.
- prime_en  in  1  1 = line-priming mode enabled.
- line_len  in  DEPTH_WIDTH+1  priming threshold in words; sampled every cycle.
- wr_en  in  1  write request.
- wr_data  in  DATA_WIDTH  write data.
- wr_vld  out  1  write-ready (not full); a write is accepted when wr_en & wr_vld.
- rd_en  in  1  pop request; a pop is accepted when rd_en & rd_vld.
- rd_vld  out  1  rd_data holds a valid head word.
- rd_data  out  DATA_WIDTH  head word (FWFT); holds its value while rd_vld=1 and no pop occurs.
- count  out  DEPTH_WIDTH+1  words stored, including the output stage.
- almost_full  out  1  count >= AF_LEVEL.
- almost_empty  out  1  count <= AE_LEVEL.
- overflow  out  1  sticky: wr_en seen while wr_vld=0.
- underflow  out  1  sticky: rd_en seen while rd_vld=0.

Behaviour:
- Reset (rst=1 at a clk edge): count=0, wr_vld=1, rd_vld=0, rd_data=0, almost_full=0, almost_empty=1, overflow=0, underflow=0, primed=0, pointers=0.
- rst has priority over flush, and flush has priority over wr/rd.
- Flush gives the same register state as reset. It does not change parameter-derived constants.
- Storage is inferred block RAM with a registered read, plus a one-word output register.
- Capacity is exactly 2**DEPTH_WIDTH. wr_vld = (count < 2**DEPTH_WIDTH) and is registered.
- count updates on the edge of the accepted event: +1 on write only, -1 on pop only, unchanged on write+pop.
- Write-to-read latency, empty FIFO, prime_en=0: a word accepted at edge N has rd_vld=1 and rd_data=word after edge N+2.
- Back-to-back pops with rd_en held high deliver one word per cycle with no bubbles while count >= 2.
- Ordering is strict FIFO. Pointers wrap modulo 2**DEPTH_WIDTH with no lost or duplicated word.
- Full plus simultaneous wr_en and rd_en: the write is rejected (wr_vld=0 that cycle), overflow is set, and the pop proceeds. wr_vld returns to 1 the next cycle.
- Empty plus simultaneous wr_en and rd_en: the pop is rejected, underflow is set, and the write is accepted.
- Priming state machine, states IDLE and PRIMED:
  - IDLE -> PRIMED when prime_en=0, or when count >= line_len (line_len=0 counts as satisfied).
  - PRIMED -> IDLE when count reaches 0 with no write in the same cycle, or on flush/rst.
  - While IDLE, rd_vld is forced to 0 even if data is present; rd_data may pre-load.
  - Deasserting prime_en while IDLE moves to PRIMED on the next edge.
- almost_full and almost_empty are registered and consistent with count in the same cycle.
- overflow and underflow stay set until rst or flush.
- No combinational path exists from wr_en/rd_en to wr_vld/rd_vld.

Test Plan:
- DATA_WIDTH=8, DEPTH_WIDTH=4. After reset, write 0x01..0x10 on 16 consecutive cycles, then hold rd_en=1 -> wr_vld=0 after the 16th write and count=16; reads return 0x01..0x10 in order with no gap; count=0 and rd_vld=0 at the end.
- Empty FIFO, single write of 0xA5 at edge N -> rd_vld=1 and rd_data=0xA5 after edge N+2; rd_en pulse -> count 1->0, almost_empty=1.
- Full FIFO, one cycle of wr_en=1, rd_en=1, wr_data=0x77 -> 0x77 is not stored, overflow=1, count=15; next cycle write 0x78 is accepted and is read out after 0x10.
- prime_en=1, line_len=5, write 0x10..0x14 one per cycle -> rd_vld stays 0 through count=4 and rises after count=5; draining all 5 words returns to IDLE; a new single write keeps rd_vld=0.
- Wrap and continuous streaming: 100 words with random wr_en/rd_en at about 50% each -> scoreboard matches exactly; count never exceeds 16; no overflow/underflow when the handshake is respected.
- Reset and flush mid-operation: with count=9, assert flush (and separately rst) for one cycle -> next cycle count=0, rd_vld=0, wr_vld=1, sticky flags 0; a following write of 0x3C is read back first.
